// File: rtl/dispatch_queue.sv
// rtl/dispatch_queue.sv - in-order uop buffer steering the head uop to one of four reservation stations
// uop layout: {rd[55:51], rs1[50:46], rs2[45:41], imm[40:9], srcB[8], alu_ctrl[7:4], rs_mask[3:0]}
module dispatch_queue #(
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int UOP_W = 56
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [UOP_W-1:0] in_uop,
  output logic             in_ready,
  input  logic [3:0]       rs_ready,
  output logic [3:0]       rs_valid,
  output logic [UOP_W-1:0] rs_uop,
  output logic [PTR_W:0]   occupancy,
  output logic             drop_err
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0] ZERO_CNT = '0;

  logic [UOP_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wp_q, wp_d;
  logic [PTR_W-1:0] rp_q, rp_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             drop_err_q, drop_err_d;

  logic       not_empty;
  logic [3:0] head_mask;
  logic [3:0] sel;
  logic [3:0] grant;
  logic       enq;
  logic       dispatch_fire;
  logic       drop;
  logic       deq;

  assign rs_uop    = mem_q[rp_q];
  assign head_mask = rs_uop[3:0];
  assign not_empty = (cnt_q != ZERO_CNT);
  assign in_ready  = (cnt_q != FULL_CNT) && !flush;
  assign enq       = in_valid && in_ready;
  assign sel       = head_mask & rs_ready;

  // Highest-numbered ready RS wins when a uop can go to more than one.
  always_comb begin
    grant = 4'b0000;
    if (sel[3])      grant = 4'b1000;
    else if (sel[2]) grant = 4'b0100;
    else if (sel[1]) grant = 4'b0010;
    else if (sel[0]) grant = 4'b0001;
  end

  assign rs_valid      = (not_empty && (head_mask != 4'b0000) && !flush) ? grant : 4'b0000;
  assign dispatch_fire = |(rs_valid & rs_ready);
  assign drop          = not_empty && (head_mask == 4'b0000) && !flush;
  assign deq           = dispatch_fire || drop;

  always_comb begin
    wp_d       = wp_q;
    rp_d       = rp_q;
    cnt_d      = cnt_q;
    drop_err_d = drop;
    if (flush) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (enq) wp_d = wp_q + 1'b1;
      if (deq) rp_d = rp_q + 1'b1;
      case ({enq, deq})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q       <= '0;
      rp_q       <= '0;
      cnt_q      <= '0;
      drop_err_q <= 1'b0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      cnt_q      <= cnt_d;
      drop_err_q <= drop_err_d;
    end
  end

  // Storage is not reset; only pointers and count define valid contents.
  always_ff @(posedge clk) begin
    if (enq && !rst) mem_q[wp_q] <= in_uop;
  end

  assign occupancy = cnt_q;
  assign drop_err  = drop_err_q;

endmodule

// File: tb/tb_dispatch_queue.sv
// tb/tb_dispatch_queue.sv - scoreboard bench for dispatch_queue
module tb_dispatch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [55:0] in_uop;
  logic        in_ready;
  logic [3:0]  rs_ready;
  logic [3:0]  rs_valid;
  logic [55:0] rs_uop;
  logic [3:0]  occupancy;
  logic        drop_err;

  always #5 clk = ~clk;

  dispatch_queue #(.DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_uop    (in_uop),
    .in_ready  (in_ready),
    .rs_ready  (rs_ready),
    .rs_valid  (rs_valid),
    .rs_uop    (rs_uop),
    .occupancy (occupancy),
    .drop_err  (drop_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_disp   = 0;
  int n_drop   = 0;
  logic [55:0] sb[$];
  logic [55:0] exp_u;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [55:0] mk_uop(input logic [31:0] imm, input logic [3:0] mask);
    return {5'd1, 5'd2, 5'd3, imm, 1'b0, 4'd5, mask};
  endfunction

  function automatic logic [3:0] hi_bit(input logic [3:0] v);
    if (v[3]) return 4'b1000;
    if (v[2]) return 4'b0100;
    if (v[1]) return 4'b0010;
    if (v[0]) return 4'b0001;
    return 4'b0000;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: enqueue on accepted pushes, pop and compare on every RS handshake.
  always @(negedge clk) begin
    if (rst || flush) begin
      if (!rst) begin
        check_eq("flush_rs_valid", {60'd0, rs_valid}, 64'd0);
        check_eq("flush_in_ready", {63'd0, in_ready}, 64'd0);
      end
      sb.delete();
    end else begin
      if (drop_err) n_drop++;
      if (rs_uop[3:0] == 4'b0000) check_eq("zero_mask_rs_valid", {60'd0, rs_valid}, 64'd0);
      if (|(rs_valid & rs_ready)) begin
        n_disp++;
        if (sb.size() == 0) begin
          check_eq("dispatch_with_sb_empty", {60'd0, rs_valid}, 64'd0);
        end else begin
          exp_u = sb.pop_front();
          check_eq("disp_uop", {8'd0, rs_uop}, {8'd0, exp_u});
          check_eq("disp_grant", {60'd0, rs_valid}, {60'd0, hi_bit(exp_u[3:0] & rs_ready)});
        end
      end
      if (in_valid && in_ready && in_uop[3:0] != 4'b0000) sb.push_back(in_uop);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_flush();
    in_valid = 1'b0;
    rs_ready = 4'b0000;
    flush    = 1'b1;
    cyc();
    flush    = 1'b0;
  endtask

  initial begin
    int d0;
    int p0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_uop = '0; rs_ready = 4'b0000;
    repeat (2) cyc();
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_rs_valid", {60'd0, rs_valid}, 64'd0);
    check_eq("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check_eq("rst_occupancy", {60'd0, occupancy}, 64'd0);
    check_eq("rst_drop_err", {63'd0, drop_err}, 64'd0);
    cyc();

    // Fill to full with all RS stalled, then drain on RS3.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_uop   = mk_uop(32'd100 + i, 4'b1000);
      @(negedge clk);
      check_eq("fill_in_ready", {63'd0, in_ready}, 64'd1);
      cyc();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("full_in_ready", {63'd0, in_ready}, 64'd0);
    check_eq("full_occupancy", {60'd0, occupancy}, 64'd8);
    cyc();
    d0 = n_disp;
    rs_ready = 4'b1000;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq("drain_rs_valid", {60'd0, rs_valid}, 64'h8);
      cyc();
    end
    @(negedge clk);
    check_eq("drain_occupancy", {60'd0, occupancy}, 64'd0);
    check_eq("drain_count", n_disp - d0, 8);
    cyc();

    // Head-of-line blocking: MUL at head stalls a ready load behind it.
    do_flush();
    rs_ready = 4'b0010;
    in_valid = 1'b1; in_uop = mk_uop(32'd200, 4'b0100);
    cyc();
    in_uop = mk_uop(32'd201, 4'b0010);
    @(negedge clk);
    check_eq("hol_rs_valid_a", {60'd0, rs_valid}, 64'd0);
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("hol_rs_valid_b", {60'd0, rs_valid}, 64'd0);
      check_eq("hol_occupancy", {60'd0, occupancy}, 64'd2);
      cyc();
    end
    rs_ready = 4'b0110;
    @(negedge clk);
    check_eq("hol_mul", {60'd0, rs_valid}, 64'h4);
    cyc();
    @(negedge clk);
    check_eq("hol_lw", {60'd0, rs_valid}, 64'h2);
    cyc();
    @(negedge clk);
    check_eq("hol_occupancy_end", {60'd0, occupancy}, 64'd0);
    cyc();

    // Multi-bit mask priority.
    rs_ready = 4'b0000;
    in_valid = 1'b1; in_uop = mk_uop(32'd300, 4'b1001);
    cyc();
    in_uop = mk_uop(32'd301, 4'b1001);
    cyc();
    in_valid = 1'b0;
    rs_ready = 4'b1111;
    @(negedge clk);
    check_eq("prio_all_ready", {60'd0, rs_valid}, 64'h8);
    cyc();
    rs_ready = 4'b0001;
    @(negedge clk);
    check_eq("prio_low_ready", {60'd0, rs_valid}, 64'h1);
    cyc();
    rs_ready = 4'b0000;

    // Zero-mask uop sandwiched between two logic uops.
    d0 = n_disp;
    p0 = n_drop;
    in_valid = 1'b1; in_uop = mk_uop(32'd400, 4'b1000);
    cyc();
    in_uop = mk_uop(32'd401, 4'b0000);
    cyc();
    in_uop = mk_uop(32'd402, 4'b1000);
    cyc();
    in_valid = 1'b0;
    rs_ready = 4'b1000;
    repeat (8) cyc();
    @(negedge clk);
    check_eq("zero_drop_pulses", n_drop - p0, 1);
    check_eq("zero_dispatches", n_disp - d0, 2);
    check_eq("zero_occupancy", {60'd0, occupancy}, 64'd0);
    cyc();

    // Streaming through with pointers wrapping twice.
    do_flush();
    d0 = n_disp;
    rs_ready = 4'b1111;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_uop   = mk_uop(32'd500 + i, 4'b0001 << (i % 4));
      @(negedge clk);
      check_eq("stream_in_ready", {63'd0, in_ready}, 64'd1);
      if (i > 0) check_eq("stream_occupancy", {60'd0, occupancy}, 64'd1);
      cyc();
    end
    in_valid = 1'b0;
    cyc();
    @(negedge clk);
    check_eq("stream_dispatches", n_disp - d0, 20);
    check_eq("stream_occupancy_end", {60'd0, occupancy}, 64'd0);
    cyc();

    // Flush, then reset, against 5 queued entries with a live handshake.
    for (int pass = 0; pass < 2; pass++) begin
      rs_ready = 4'b0000;
      for (int i = 0; i < 5; i++) begin
        in_valid = 1'b1;
        in_uop   = mk_uop(32'd600 + i, 4'b0100);
        cyc();
      end
      in_uop   = mk_uop(32'd700, 4'b0100);
      rs_ready = 4'b0100;
      if (pass == 0) flush = 1'b1;
      else rst = 1'b1;
      cyc();
      flush = 1'b0; rst = 1'b0; in_valid = 1'b0; rs_ready = 4'b0000;
      @(negedge clk);
      check_eq("clear_occupancy", {60'd0, occupancy}, 64'd0);
      check_eq("clear_drop_err", {63'd0, drop_err}, 64'd0);
      check_eq("clear_in_ready", {63'd0, in_ready}, 64'd1);
      cyc();
      in_valid = 1'b1; in_uop = mk_uop(32'd710 + pass, 4'b0100);
      cyc();
      in_valid = 1'b0; rs_ready = 4'b0100;
      @(negedge clk);
      check_eq("clear_first_rs_valid", {60'd0, rs_valid}, 64'h4);
      check_eq("clear_first_imm", {32'd0, rs_uop[40:9]}, 64'd710 + pass);
      cyc();
      rs_ready = 4'b0000;
    end

    @(negedge clk);
    check_eq("sb_empty_end", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
